// File: rtl/bram_if_pkg.sv
// Shared definitions for the port-A writer and the port-B capture side of the
// burst BRAM.
//   BRAM_DATA_W  : word width, identical on both sides of the RAM
//   BRAM_ADDR_W  : default BRAM address width (depth = 2**BRAM_ADDR_W)
//   wr_state_t   : writer control states
package bram_if_pkg;

    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/wr_skid_fifo2.sv
// Two-entry FIFO between the upstream handshake and the BRAM port-A writer.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high clear (contents, pointers, count)
//   push   : write din this cycle (ignored when full unless also popping)
//   pop    : drop the head entry this cycle (ignored when empty)
//   din    : data to push
//   dout   : current head entry (valid when !empty)
//   count  : number of stored entries, 0..2
//   empty  : count == 0
//   full   : count == 2
// Push and pop in the same cycle are allowed and leave the count unchanged.
module wr_skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic [1:0]   wen;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count_reg == 2'd0);
    assign full    = (count_reg == 2'd2);
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];

    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    for (genvar gi = 0; gi < 2; gi++) begin : g_wen
        assign wen[gi] = do_push && (wr_ptr_reg == 1'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wen[i]) begin
                    mem_reg[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bram_porta_writer.sv
// Burst writer for BRAM port A.
//   writeclk      : clock, rising edge
//   rst           : asynchronous active-high reset; drops any buffered words
//   start         : one-cycle pulse, honoured only in IDLE
//   base_addr     : first write address of the burst
//   word_count    : burst length, 0..2**ADDR_W
//   din_valid/din : upstream word, taken when din_ready is also high
//   din_ready     : block can accept din this cycle (registered state only)
//   hold          : arbiter stall; no port-A write is issued while high
//   ena/wea/addra/dina : registered BRAM port-A controls
//   busy          : high while in WRITE
//   done          : one-cycle pulse after the last write was issued
//   words_written : writes issued in the current or most recent burst
// Words flow din -> 2-entry FIFO -> port-A registers; one write per cycle,
// addresses increment from base_addr and wrap at the top of the RAM.
module bram_porta_writer
    import bram_if_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              writeclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    input  logic              hold,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int CNT_W = ADDR_W + 1;

    wr_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [CNT_W-1:0]  rem_accept_reg;
    logic [CNT_W-1:0]  rem_write_reg;
    logic [CNT_W-1:0]  words_written_reg;
    logic              ena_reg;
    logic              wea_reg;
    logic [ADDR_W-1:0] addra_reg;
    logic [DATA_W-1:0] dina_reg;

    logic [DATA_W-1:0] fifo_dout;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic in_idle;
    logic in_write;
    logic accept;
    logic issue;
    logic last_issue;

    assign in_idle  = (state_reg == IDLE);
    assign in_write = (state_reg == WRITE);

    // Only words still owed to this burst are taken; extras stay upstream.
    assign din_ready  = in_write && (fifo_count != 2'd2) && (rem_accept_reg != '0);
    assign accept     = din_valid && din_ready;
    assign issue      = in_write && !fifo_empty && !hold && (rem_write_reg != '0);
    assign last_issue = issue && (rem_write_reg == CNT_W'(1));

    wr_skid_fifo2 #(
        .W (DATA_W)
    ) u_fifo (
        .clk   (writeclk),
        .rst   (rst),
        .push  (accept && !fifo_full),
        .pop   (issue),
        .din   (din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    // An empty burst completes without touching the RAM.
                    state_next = (word_count != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (last_issue) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge writeclk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            wr_addr_reg       <= '0;
            rem_accept_reg    <= '0;
            rem_write_reg     <= '0;
            words_written_reg <= '0;
            ena_reg           <= 1'b0;
            wea_reg           <= 1'b0;
            addra_reg         <= '0;
            dina_reg          <= '0;
        end else begin
            state_reg <= state_next;
            ena_reg   <= issue;
            wea_reg   <= issue;

            if (in_idle && start) begin
                wr_addr_reg       <= base_addr;
                rem_accept_reg    <= word_count;
                rem_write_reg     <= word_count;
                words_written_reg <= '0;
            end else begin
                if (accept) begin
                    rem_accept_reg <= rem_accept_reg - CNT_W'(1);
                end
                // Address and data keep their last values on idle cycles.
                if (issue) begin
                    addra_reg         <= wr_addr_reg;
                    dina_reg          <= fifo_dout;
                    wr_addr_reg       <= wr_addr_reg + ADDR_W'(1);
                    rem_write_reg     <= rem_write_reg - CNT_W'(1);
                    words_written_reg <= words_written_reg + CNT_W'(1);
                end
            end
        end
    end

    assign ena           = ena_reg;
    assign wea           = wea_reg;
    assign addra         = addra_reg;
    assign dina          = dina_reg;
    assign words_written = words_written_reg;

endmodule

// File: tb/tb_bram_porta_writer.sv
module tb_bram_porta_writer;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          writeclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_ready;
    logic          hold = 1'b0;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;

    bram_porta_writer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .writeclk      (writeclk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .din_valid     (din_valid),
        .din           (din),
        .din_ready     (din_ready),
        .hold          (hold),
        .ena           (ena),
        .wea           (wea),
        .addra         (addra),
        .dina          (dina),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 writeclk = ~writeclk;

    int cyc = 0;
    always @(posedge writeclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observed traffic, sampled on the falling edge.
    logic [DW-1:0] acc_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int done_cnt, done_cyc, first_acc_cyc, first_wea_cyc, last_wea_cyc;

    always @(negedge writeclk) begin
        if (!rst) begin
            if (din_valid && din_ready) begin
                if (acc_q.size() == 0) first_acc_cyc = cyc;
                acc_q.push_back(din);
            end
            if (wea) begin
                if (wa_q.size() == 0) first_wea_cyc = cyc;
                last_wea_cyc = cyc;
                wa_q.push_back(addra);
                wd_q.push_back(dina);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        acc_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        first_acc_cyc = 0;
        first_wea_cyc = 0;
        last_wea_cyc = 0;
    endtask

    // Run one burst: random valid/hold, optional forced hold at the start and
    // an optional stray start pulse at iteration restart_at.
    task automatic burst(input logic [AW-1:0] b, input logic [AW:0] n,
                         input int hold_pct, input int valid_pct,
                         input int restart_at, input int hold_first,
                         output int start_cyc);
        logic [DW-1:0] supply[$];
        int sidx;
        int budget;
        sidx   = 0;
        budget = 20 * int'(n) + 200;
        for (int i = 0; i < int'(n) + 8; i++) supply.push_back($urandom);
        clear_mon();
        @(posedge writeclk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        din_valid = 1'b0; hold = 1'b0;
        start_cyc = cyc;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            @(posedge writeclk); #1;
            if (hold_first > 0 && k == hold_first) begin
                check("hold_accepts", acc_q.size(), 2);
                check("hold_no_write", wa_q.size(), 0);
                check("hold_ready_low", din_ready, 0);
            end
            start = (k == restart_at);
            if (start) begin
                base_addr  = b ^ 10'h155;
                word_count = n + 3;
            end
            hold      = (k < hold_first) ? 1'b1 : ($urandom_range(99) < hold_pct);
            din_valid = ($urandom_range(99) < valid_pct);
            din       = supply[sidx];
            @(negedge writeclk);
            if (din_valid && din_ready) sidx++;
        end
        if (done_cnt == 0) check("burst_timeout", 0, 1);
        @(posedge writeclk); #1;
        start = 1'b0; din_valid = 1'b0; hold = 1'b0;
        @(posedge writeclk); #1;
    endtask

    // Expected: word i of the accepted stream lands at (base + i) mod depth.
    task automatic check_burst(input string tag, input logic [AW-1:0] b, input logic [AW:0] n);
        int bad;
        bit seen[int];
        bad = 0;
        check({tag, "_accepts"}, acc_q.size(), n);
        check({tag, "_writes"}, wa_q.size(), n);
        for (int i = 0; i < wa_q.size() && i < acc_q.size(); i++) begin
            if (wa_q[i] !== AW'((int'(b) + i) % DEPTH)) bad++;
            if (wd_q[i] !== acc_q[i]) bad++;
            seen[int'(wa_q[i])] = 1'b1;
        end
        check({tag, "_seq_bad"}, bad, 0);
        check({tag, "_distinct"}, seen.num(), n);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_words_written"}, words_written, n);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            hold_pct;
        int            valid_pct;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int sc;
        int nacc;
        logic [AW-1:0] rb;
        logic [AW:0]   rn;

        tbl[0] = '{10'h010, 11'd4,    0,  100, 10'h013};
        tbl[1] = '{10'h3FE, 11'd4,    0,  100, 10'h001};
        tbl[2] = '{10'h000, 11'd1024, 0,  100, 10'h3FF};
        tbl[3] = '{10'h200, 11'd7,    30, 70,  10'h206};
        tbl[4] = '{10'h3F0, 11'd20,   0,  100, 10'h003};

        // Reset state
        repeat (3) @(posedge writeclk);
        #1;
        check("rst_ena", ena, 0);
        check("rst_wea", wea, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", din_ready, 0);
        check("rst_ww", words_written, 0);
        rst = 1'b0;

        // Table-driven bursts
        foreach (tbl[t]) begin
            burst(tbl[t].base, tbl[t].cnt, tbl[t].hold_pct, tbl[t].valid_pct, -1, 0, sc);
            check_burst($sformatf("tbl%0d", t), tbl[t].base, tbl[t].cnt);
            if (wa_q.size() > 0) check($sformatf("tbl%0d_last_addr", t), wa_q[$], tbl[t].exp_last);
            if (tbl[t].hold_pct == 0 && tbl[t].valid_pct == 100) begin
                check($sformatf("tbl%0d_latency", t), first_wea_cyc - first_acc_cyc, 2);
                check($sformatf("tbl%0d_throughput", t), last_wea_cyc - first_wea_cyc, int'(tbl[t].cnt) - 1);
            end
            $display("burst tbl%0d base=0x%03h count=%0d writes=%0d", t, tbl[t].base, tbl[t].cnt, wa_q.size());
        end

        // Zero count: done the cycle after start, nothing written
        burst(10'h155, 11'd0, 0, 100, -1, 0, sc);
        check("zero_done_latency", done_cyc - sc, 1);
        check_burst("zero", 10'h155, 11'd0);
        $display("burst zero count done_latency=%0d", done_cyc - sc);

        // Stray start during a 6-word burst is ignored
        burst(10'h080, 11'd6, 0, 100, 2, 0, sc);
        check_burst("restart", 10'h080, 11'd6);
        $display("burst restart-ignored writes=%0d", wa_q.size());

        // Hold high for the first 5 cycles of the burst
        burst(10'h040, 11'd6, 0, 100, -1, 5, sc);
        check_burst("hold", 10'h040, 11'd6);
        $display("burst hold writes=%0d", wa_q.size());

        // Over-supply: valid stays high well past the burst
        burst(10'h020, 11'd3, 0, 100, -1, 0, sc);
        repeat (6) begin
            @(posedge writeclk); #1;
            din_valid = 1'b1;
            check("over_ready_low", din_ready, 0);
        end
        din_valid = 1'b0;
        check_burst("over", 10'h020, 11'd3);
        $display("burst over-supply accepts=%0d", acc_q.size());

        // Reset mid-burst after 3 of 8 words
        clear_mon();
        @(posedge writeclk); #1;
        start = 1'b1; base_addr = 10'h100; word_count = 11'd8;
        @(posedge writeclk); #1;
        start = 1'b0;
        nacc = 0;
        for (int k = 0; k < 40 && nacc < 3; k++) begin
            din_valid = 1'b1;
            din = 32'hC000_0000 + DW'(nacc);
            @(negedge writeclk);
            if (din_valid && din_ready) nacc++;
            @(posedge writeclk); #1;
        end
        din_valid = 1'b0;
        check("prerst_wea", wea, 1);
        check("prerst_addra", addra, 10'h101);
        #2 rst = 1'b1;
        #1;
        check("arst_ena", ena, 0);
        check("arst_wea", wea, 0);
        check("arst_addra", addra, 0);
        check("arst_dina", dina, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", din_ready, 0);
        check("arst_ww", words_written, 0);
        @(posedge writeclk); #2;
        rst = 1'b0;
        #1;
        check("postrst_busy", busy, 0);
        $display("reset mid-burst after %0d accepts", nacc);
        burst(10'h111, 11'd8, 0, 100, -1, 0, sc);
        check_burst("fresh", 10'h111, 11'd8);
        $display("burst fresh-after-reset writes=%0d", wa_q.size());

        // Randomized bursts against the address/data model
        for (int r = 0; r < 10; r++) begin
            rb = AW'($urandom_range(DEPTH - 1));
            rn = (AW + 1)'($urandom_range(40, 1));
            burst(rb, rn, $urandom_range(60), $urandom_range(100, 30), -1, 0, sc);
            check_burst($sformatf("rand%0d", r), rb, rn);
            $display("burst rand%0d base=0x%03h count=%0d writes=%0d", r, rb, rn, wa_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
